gold_spi_slave: RTL and testbench

- User-SPI slave with a small byte-wide register file, clocked by the 25 MHz system clock.
- Controls the MGT power enable, debug LEDs and debug outputs.
- Bridges a second user chip-select straight through to the configuration QSPI flash.
- Sits at the top level of the gold (fallback) FPGA image, between the board SPI header and the on-chip control signals.

---
 rtl/gold_spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/gold_spi_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_gold_spi_slave.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gold_spi_pkg.sv
// Shared constants and types for the gold-image user-SPI register slave.
package gold_spi_pkg;

    localparam logic [7:0] ID_VALUE_DEF = 8'h47;
    localparam logic [7:0] VERSION_DEF  = 8'h01;

    localparam logic [6:0] ADDR_ID      = 7'h00;
    localparam logic [6:0] ADDR_VERSION = 7'h01;
    localparam logic [6:0] ADDR_CTRL    = 7'h02;
    localparam logic [6:0] ADDR_LED     = 7'h03;
    localparam logic [6:0] ADDR_DBG     = 7'h04;
    localparam logic [6:0] ADDR_SCRATCH = 7'h05;

    localparam int CMD_RD_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with a third stage
// providing single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw input through the three stages
    always_comb begin
        sync_d = {sync_q[1:0], d};
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q    = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/gold_spi_slave.sv
// User-SPI (mode 0) register slave for the gold image, plus a pass-through
// bridge from the second chip-select to the configuration QSPI flash.
module gold_spi_slave
    import gold_spi_pkg::*;
#(
    parameter logic [7:0] ID_VALUE = ID_VALUE_DEF,
    parameter logic [7:0] VERSION  = VERSION_DEF,
    parameter int         LED_W    = 4,
    parameter int         DBG_W    = 8
) (
    input  logic             sysclk25,
    input  logic             rst,
    input  logic             usr_spi_clk,
    input  logic [1:0]       usr_spi_cs,
    input  logic             usr_spi_mosi,
    output logic             usr_spi_miso,
    output logic             qspi_cs,
    output logic             qspi_mosi,
    input  logic             qspi_miso,
    output logic             mgt_pwr_en,
    output logic [LED_W-1:0] dbg_led,
    output logic [DBG_W-1:0] dbg_out
);

    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s;
    logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_sync_sclk (
        .clk(sysclk25), .rst(rst), .d(usr_spi_clk),
        .q(sclk_lvl_unused), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    // Sync stages reset low, so a chip-select already held low across reset
    // produces no falling edge and the slave waits for a fresh frame.
    spi_sync_edge u_sync_cs (
        .clk(sysclk25), .rst(rst), .d(usr_spi_cs[1]),
        .q(cs_lvl_unused), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_sync_edge u_sync_mosi (
        .clk(sysclk25), .rst(rst), .d(usr_spi_mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       tx_q, tx_d;
    logic             rd_q, rd_d;
    logic [6:0]       addr_q, addr_d;
    logic             ctrl_q, ctrl_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [DBG_W-1:0] dbg_q, dbg_d;
    logic [7:0]       scratch_q, scratch_d;

    logic       byte_done_s, frame_start_s, active_s, cmd_done_s, wr_stb_s, rd_load_s;
    logic [7:0] rx_byte_s, rdata_s;

    assign byte_done_s = sclk_rise_s & (bit_cnt_q == 3'd7);
    assign rx_byte_s   = {rx_q[6:0], mosi_s};

    // FSM state register
    always_ff @(posedge sysclk25) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; chip-select release aborts from any active state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = cs_fall_s ? ST_CMD : ST_IDLE;
            ST_CMD: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else if (byte_done_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: state_d = cs_rise_s ? ST_IDLE : ST_DATA;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: per-cycle strobes for the datapath
    always_comb begin
        frame_start_s = 1'b0;
        active_s      = 1'b0;
        cmd_done_s    = 1'b0;
        wr_stb_s      = 1'b0;
        rd_load_s     = 1'b0;
        case (state_q)
            ST_IDLE: frame_start_s = cs_fall_s;
            ST_CMD: begin
                active_s   = ~cs_rise_s;
                cmd_done_s = ~cs_rise_s & byte_done_s;
            end
            ST_DATA: begin
                active_s  = ~cs_rise_s;
                wr_stb_s  = ~cs_rise_s & byte_done_s & ~rd_q;
                rd_load_s = ~cs_rise_s & rd_q & sclk_fall_s & (bit_cnt_q == 3'd0);
            end
            default: frame_start_s = 1'b0;
        endcase
    end

    // Register-file read mux at the current address
    always_comb begin
        rdata_s = 8'h00;
        case (addr_q)
            ADDR_ID:      rdata_s = ID_VALUE;
            ADDR_VERSION: rdata_s = VERSION;
            ADDR_CTRL:    rdata_s = {7'h00, ctrl_q};
            ADDR_LED:     rdata_s = 8'(led_q);
            ADDR_DBG:     rdata_s = 8'(dbg_q);
            ADDR_SCRATCH: rdata_s = scratch_q;
            default:      rdata_s = 8'h00;
        endcase
    end

    // Shift registers, address pointer and register-file writes
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        ctrl_d    = ctrl_q;
        led_d     = led_q;
        dbg_d     = dbg_q;
        scratch_d = scratch_q;
        if (frame_start_s) begin
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
        end else if (active_s) begin
            if (sclk_rise_s) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte_s;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
            if (rd_load_s) begin
                tx_d = rdata_s;
            end else if (sclk_fall_s) begin
                tx_d = {tx_q[6:0], 1'b0};
            end else begin
                tx_d = tx_q;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
        if (cmd_done_s) begin
            rd_d   = rx_byte_s[CMD_RD_BIT];
            addr_d = rx_byte_s[6:0];
        end else if (wr_stb_s || rd_load_s) begin
            addr_d = addr_q + 7'd1;
        end else begin
            addr_d = addr_q;
        end
        if (wr_stb_s) begin
            case (addr_q)
                ADDR_CTRL:    ctrl_d    = rx_byte_s[0];
                ADDR_LED:     led_d     = rx_byte_s[LED_W-1:0];
                ADDR_DBG:     dbg_d     = rx_byte_s[DBG_W-1:0];
                ADDR_SCRATCH: scratch_d = rx_byte_s;
                default:      scratch_d = scratch_q;
            endcase
        end else begin
            scratch_d = scratch_q;
        end
    end

    // Datapath and register-file flops
    always_ff @(posedge sysclk25) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            rd_q      <= 1'b0;
            addr_q    <= 7'h00;
            ctrl_q    <= 1'b0;
            led_q     <= '0;
            dbg_q     <= '0;
            scratch_q <= 8'h00;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            ctrl_q    <= ctrl_d;
            led_q     <= led_d;
            dbg_q     <= dbg_d;
            scratch_q <= scratch_d;
        end
    end

    assign mgt_pwr_en = ctrl_q;
    assign dbg_led    = led_q;
    assign dbg_out    = dbg_q;

    assign qspi_cs   = usr_spi_cs[0];
    assign qspi_mosi = usr_spi_mosi;

    // Flash owns MISO whenever it is selected; the register slave otherwise
    always_comb begin
        if (!usr_spi_cs[0]) begin
            usr_spi_miso = qspi_miso;
        end else if (!usr_spi_cs[1]) begin
            usr_spi_miso = tx_q[7];
        end else begin
            usr_spi_miso = 1'b0;
        end
    end

endmodule

// File: tb/tb_gold_spi_slave.sv
// Directed bench for gold_spi_slave: a host bit-bangs mode-0 SPI frames and
// compares received bytes and control outputs against hand-computed values.
module tb_gold_spi_slave;

    logic       sysclk25 = 1'b0;
    logic       rst = 1'b1;
    logic       usr_spi_clk = 1'b0;
    logic [1:0] usr_spi_cs = 2'b11;
    logic       usr_spi_mosi = 1'b0;
    logic       usr_spi_miso;
    logic       qspi_cs;
    logic       qspi_mosi;
    logic       qspi_miso = 1'b0;
    logic       mgt_pwr_en;
    logic [3:0] dbg_led;
    logic [7:0] dbg_out;

    int n_checks = 0;
    int n_fail   = 0;

    gold_spi_slave dut (
        .sysclk25(sysclk25), .rst(rst), .usr_spi_clk(usr_spi_clk),
        .usr_spi_cs(usr_spi_cs), .usr_spi_mosi(usr_spi_mosi),
        .usr_spi_miso(usr_spi_miso), .qspi_cs(qspi_cs), .qspi_mosi(qspi_mosi),
        .qspi_miso(qspi_miso), .mgt_pwr_en(mgt_pwr_en), .dbg_led(dbg_led),
        .dbg_out(dbg_out)
    );

    always #20 sysclk25 = ~sysclk25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk25);
    endtask

    // Host-side mode-0 transfer: MISO is sampled just before each SCLK rise
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            usr_spi_mosi = tx[7-i];
            tick(8);
            rx[7-i] = usr_spi_miso;
            usr_spi_clk = 1'b1;
            tick(8);
            usr_spi_clk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        usr_spi_cs[1] = 1'b0;
        tick(8);
    endtask

    task automatic cs_hi();
        tick(8);
        usr_spi_cs[1] = 1'b1;
        tick(8);
    endtask

    logic [7:0] rx;
    logic [7:0] exp_rd [5];

    initial begin
        exp_rd = '{8'h01, 8'h0A, 8'h5C, 8'hC3, 8'h00};

        tick(4);
        rst = 1'b0;
        tick(2);
        chk("rst_mgt", 32'(mgt_pwr_en), 32'h0);
        chk("rst_led", 32'(dbg_led), 32'h0);
        chk("rst_dbg", 32'(dbg_out), 32'h0);
        chk("rst_miso", 32'(usr_spi_miso), 32'h0);
        chk("rst_qspi_cs", 32'(qspi_cs), 32'h1);

        // ID read with auto-increment into VERSION
        cs_lo();
        spi_xfer(8'h80, 8, rx); chk("id_cmd_byte", 32'(rx), 32'h00);
        spi_xfer(8'h00, 8, rx); chk("id_byte", 32'(rx), 32'h47);
        spi_xfer(8'h00, 8, rx); chk("version_byte", 32'(rx), 32'h01);
        cs_hi();

        // Write burst CTRL/LED/DBG
        cs_lo();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h0A, 8, rx);
        spi_xfer(8'h5C, 8, rx);
        cs_hi();
        chk("wr_mgt", 32'(mgt_pwr_en), 32'h1);
        chk("wr_led", 32'(dbg_led), 32'hA);
        chk("wr_dbg", 32'(dbg_out), 32'h5C);

        // Write SCRATCH then read it back
        cs_lo();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hC3, 8, rx);
        cs_hi();
        cs_lo();
        spi_xfer(8'h85, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("scratch_rb", 32'(rx), 32'hC3);
        cs_hi();

        // Burst read 0x02..0x06
        cs_lo();
        spi_xfer(8'h82, 8, rx);
        for (int i = 0; i < 5; i++) begin
            spi_xfer(8'h00, 8, rx);
            chk($sformatf("burst_rd_%0d", i + 2), 32'(rx), 32'(exp_rd[i]));
        end
        cs_hi();

        // Unmapped read
        cs_lo();
        spi_xfer(8'h90, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("unmapped_rd", 32'(rx), 32'h00);
        cs_hi();

        // Read at 0x7F wraps to ID
        cs_lo();
        spi_xfer(8'hFF, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("rd_7f", 32'(rx), 32'h00);
        spi_xfer(8'h00, 8, rx); chk("rd_wrap_id", 32'(rx), 32'h47);
        cs_hi();

        // Abort after 12 bits of a SCRATCH write
        cs_lo();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hFF, 4, rx);
        cs_hi();
        cs_lo();
        spi_xfer(8'h85, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("abort_scratch", 32'(rx), 32'hC3);
        cs_hi();

        // Reset mid-frame: cs stays low, further bits must be ignored
        cs_lo();
        spi_xfer(8'h04, 8, rx);
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(4);
        chk("midrst_dbg", 32'(dbg_out), 32'h00);
        chk("midrst_mgt", 32'(mgt_pwr_en), 32'h0);
        spi_xfer(8'hAA, 8, rx);
        tick(4);
        chk("midrst_ignored", 32'(dbg_out), 32'h00);
        cs_hi();
        cs_lo();
        spi_xfer(8'h04, 8, rx);
        spi_xfer(8'h3C, 8, rx);
        cs_hi();
        chk("post_rst_dbg", 32'(dbg_out), 32'h3C);

        // Flash bridge
        usr_spi_cs = 2'b10;
        usr_spi_mosi = 1'b1;
        qspi_miso = 1'b1;
        #1;
        chk("br_qspi_cs", 32'(qspi_cs), 32'h0);
        chk("br_mosi_1", 32'(qspi_mosi), 32'h1);
        chk("br_miso_1", 32'(usr_spi_miso), 32'h1);
        tick(1);
        usr_spi_mosi = 1'b0;
        qspi_miso = 1'b0;
        #1;
        chk("br_mosi_0", 32'(qspi_mosi), 32'h0);
        chk("br_miso_0", 32'(usr_spi_miso), 32'h0);
        tick(1);
        usr_spi_cs = 2'b11;
        qspi_miso = 1'b1;
        #1;
        chk("idle_qspi_cs", 32'(qspi_cs), 32'h1);
        chk("idle_miso", 32'(usr_spi_miso), 32'h0);
        tick(8);

        // Both selects low: flash owns MISO, register slave still writes
        usr_spi_cs = 2'b10;
        qspi_miso = 1'b1;
        cs_lo();
        spi_xfer(8'h05, 8, rx); chk("both_miso_flash", 32'(rx), 32'hFF);
        spi_xfer(8'h77, 8, rx);
        cs_hi();
        usr_spi_cs = 2'b11;
        qspi_miso = 1'b0;
        tick(8);
        cs_lo();
        spi_xfer(8'h85, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("both_scratch", 32'(rx), 32'h77);
        cs_hi();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
